// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing one data_cache port among NUM_REQ memory stages.
// Ports: i_req/i_addr per requester in, o_gnt/o_dvalid/o_data back;
//        o_cache_req/o_cache_addr to the cache, i_cache_dvalid/i_cache_data from it.
module dcache_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                                i_aclk,
  input  logic                                i_areset,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   i_addr,
  output logic [NUM_REQ-1:0]                  o_dvalid,
  output logic [DATA_SIZE-1:0]                o_data,
  output logic [NUM_REQ-1:0]                  o_gnt,
  output logic                                o_cache_req,
  output logic [ADDR_SIZE-1:0]                o_cache_addr,
  input  logic                                i_cache_dvalid,
  input  logic [DATA_SIZE-1:0]                i_cache_data
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   dvalid_q, dvalid_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 creq_q, creq_d;

  logic                 found;
  logic [PW-1:0]        win_idx;
  logic [PW1-1:0]       scan;

  // Scan upward from rr_ptr with wrap; first set request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + PW1'(i);
      if (scan >= PW1'(NUM_REQ))
        scan = scan - PW1'(NUM_REQ);
      if (!found && i_req[scan[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (found) state_d = S_WAIT;
      S_WAIT:  if (i_cache_dvalid) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    dvalid_d = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    creq_d   = creq_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          addr_d = i_addr[win_idx];
          creq_d = 1'b1;
          rr_ptr_d = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_WAIT: begin
        if (i_cache_dvalid) begin
          data_d   = i_cache_data;
          dvalid_d = gnt_q;
          creq_d   = 1'b0;
        end
      end
      S_RESP: begin
        gnt_d = '0;
      end
      default: begin
        gnt_d  = '0;
        creq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      dvalid_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      creq_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      dvalid_q <= dvalid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      creq_q   <= creq_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_dvalid     = dvalid_q;
  assign o_data       = data_q;
  assign o_cache_req  = creq_q;
  assign o_cache_addr = addr_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: 4 requesters, 32-bit addr/data.
// Inputs driven and outputs sampled on the falling edge.
module tb_dcache_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       i_req;
  logic [3:0][31:0] i_addr;
  logic [3:0]       o_dvalid;
  logic [31:0]      o_data;
  logic [3:0]       o_gnt;
  logic             o_cache_req;
  logic [31:0]      o_cache_addr;
  logic             i_cache_dvalid;
  logic [31:0]      i_cache_data;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;

  dcache_arbiter #(
    .NUM_REQ  (4),
    .ADDR_SIZE(32),
    .DATA_SIZE(32)
  ) dut (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .o_dvalid      (o_dvalid),
    .o_data        (o_data),
    .o_gnt         (o_gnt),
    .o_cache_req   (o_cache_req),
    .o_cache_addr  (o_cache_addr),
    .i_cache_dvalid(i_cache_dvalid),
    .i_cache_data  (i_cache_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (o_dvalid != 4'b0) dv_cnt++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_creq();
    int n;
    n = 0;
    while (!o_cache_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_cache_req) chk("creq_timeout", 64'd0, 64'd1);
  endtask

  task automatic transact(input int idx, input logic [31:0] addr,
                          input int lat, input logic [31:0] data,
                          input bit drop);
    logic [3:0] e;
    e = 4'b0001 << idx;
    wait_creq();
    chk("gnt", 64'(o_gnt), 64'(e));
    chk("cache_addr", 64'(o_cache_addr), 64'(addr));
    repeat (lat - 1) @(negedge clk);
    i_cache_dvalid = 1'b1;
    i_cache_data   = data;
    @(negedge clk);
    i_cache_dvalid = 1'b0;
    chk("dvalid", 64'(o_dvalid), 64'(e));
    chk("data", 64'(o_data), 64'(data));
    chk("creq_resp", 64'(o_cache_req), 64'd0);
    if (drop) i_req[idx] = 1'b0;
    @(negedge clk);
    chk("dvalid_pulse", 64'(o_dvalid), 64'd0);
    chk("gnt_clr", 64'(o_gnt), 64'd0);
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    i_req          = 4'b1111;
    i_cache_dvalid = 1'b0;
    i_cache_data   = '0;
    for (int i = 0; i < 4; i++) i_addr[i] = 32'h1000_0000 + 32'(i * 16);
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_dvalid", 64'(o_dvalid), 64'd0);
    chk("rst_creq", 64'(o_cache_req), 64'd0);
    chk("rst_addr", 64'(o_cache_addr), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);

    // round robin from reset: 0,1,2,3
    base = dv_cnt;
    rst  = 1'b0;
    for (int i = 0; i < 4; i++)
      transact(i, 32'h1000_0000 + 32'(i * 16), 2, 32'hA000_0000 + 32'(i), 1'b1);
    repeat (3) @(negedge clk);
    chk("rr_pulses", 64'(dv_cnt - base), 64'd4);
    chk("rr_idle_creq", 64'(o_cache_req), 64'd0);

    // single requester 2
    i_addr[2] = 32'h0000_1040;
    i_req     = 4'b0100;
    transact(2, 32'h0000_1040, 3, 32'hDEAD_BEEF, 1'b1);

    // wrap: rr_ptr=3, 1001 persistent -> 3,0,3,0
    i_req = 4'b1001;
    transact(3, i_addr[3], 1, 32'h3333_0001, 1'b0);
    transact(0, i_addr[0], 2, 32'h0000_0001, 1'b0);
    transact(3, i_addr[3], 1, 32'h3333_0002, 1'b0);
    transact(0, i_addr[0], 1, 32'h0000_0002, 1'b1);
    i_req = 4'b0000;
    repeat (2) @(negedge clk);

    // stray cache dvalid in IDLE
    i_cache_dvalid = 1'b1;
    i_cache_data   = 32'h5555_5555;
    @(negedge clk);
    i_cache_dvalid = 1'b0;
    chk("stray_dvalid", 64'(o_dvalid), 64'd0);
    chk("stray_data", 64'(o_data), 64'h0000_0002);
    @(negedge clk);
    chk("stray_dvalid2", 64'(o_dvalid), 64'd0);

    // addr change and req drop mid-WAIT (rr_ptr=1)
    i_addr[1] = 32'h0000_2000;
    i_req     = 4'b0010;
    wait_creq();
    chk("mw_gnt", 64'(o_gnt), 64'h2);
    i_addr[1] = 32'hFFFF_FFFC;
    i_req     = 4'b0000;
    repeat (2) @(negedge clk);
    chk("mw_addr", 64'(o_cache_addr), 64'h0000_2000);
    chk("mw_creq", 64'(o_cache_req), 64'd1);
    i_cache_dvalid = 1'b1;
    i_cache_data   = 32'h1234_5678;
    @(negedge clk);
    i_cache_dvalid = 1'b0;
    chk("mw_dvalid", 64'(o_dvalid), 64'h2);
    chk("mw_data", 64'(o_data), 64'h1234_5678);
    repeat (2) @(negedge clk);

    // back-to-back requester 0 (rr_ptr=2)
    base  = dv_cnt;
    i_req = 4'b0001;
    wait_creq();
    chk("b2b_gnt", 64'(o_gnt), 64'h1);
    chk("b2b_creq0", 64'(o_cache_req), 64'd1);
    i_cache_dvalid = 1'b1;
    i_cache_data   = 32'hB2B0_0001;
    @(negedge clk);
    i_cache_dvalid = 1'b0;
    chk("b2b_creq1", 64'(o_cache_req), 64'd0);
    chk("b2b_dv1", 64'(o_dvalid), 64'h1);
    @(negedge clk);
    chk("b2b_creq2", 64'(o_cache_req), 64'd0);
    chk("b2b_dv2", 64'(o_dvalid), 64'd0);
    @(negedge clk);
    chk("b2b_creq3", 64'(o_cache_req), 64'd1);
    chk("b2b_gnt2", 64'(o_gnt), 64'h1);
    i_cache_dvalid = 1'b1;
    i_cache_data   = 32'hB2B0_0002;
    @(negedge clk);
    i_cache_dvalid = 1'b0;
    i_req          = 4'b0000;
    chk("b2b_dv3", 64'(o_dvalid), 64'h1);
    chk("b2b_data", 64'(o_data), 64'hB2B0_0002);
    repeat (3) @(negedge clk);
    chk("b2b_pulses", 64'(dv_cnt - base), 64'd2);

    // reset mid-WAIT
    i_req = 4'b0100;
    wait_creq();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_gnt", 64'(o_gnt), 64'd0);
    chk("mrst_creq", 64'(o_cache_req), 64'd0);
    chk("mrst_addr", 64'(o_cache_addr), 64'd0);
    chk("mrst_data", 64'(o_data), 64'd0);
    chk("mrst_dvalid", 64'(o_dvalid), 64'd0);
    i_req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({o_gnt, o_dvalid, o_cache_req}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
